// File: rtl/if_controle_if.sv
// Instruction-memory read bus between the IF fetch sequencer (master) and memory (slave).
interface if_controle_if #(
    parameter int LARGURA = 32
);
    logic               mem_req;
    logic [LARGURA-1:0] mem_end;
    logic               mem_ack;
    logic [LARGURA-1:0] mem_dado;

    modport master (output mem_req, mem_end, input mem_ack, mem_dado);
    modport slave  (input mem_req, mem_end, output mem_ack, mem_dado);
endinterface

// File: rtl/if_controle.sv
// IF-stage fetch sequencer: PC, req/ack instruction reads, branch redirect, stall skid buffer.
// Optional IF_TIMEOUT_EN: sticky timeout_erro after TIMEOUT_CICLOS unacked request cycles.
module if_controle #(
    parameter int                 LARGURA        = 32,
    parameter logic [LARGURA-1:0] PC_RESET       = '0,
    parameter int                 TIMEOUT_CICLOS = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               PCSrc,
    input  logic [LARGURA-1:0] branch,
    input  logic               stall,
    if_controle_if.master      mem,
    output logic [LARGURA-1:0] instrucao,
    output logic [LARGURA-1:0] PC4,
    output logic               if_valido,
    output logic               timeout_erro
);
    typedef enum logic [1:0] {OCIOSO, BUSCA, SEGURA, DESCARTE} estado_t;

    estado_t            estado, prox;
    logic [LARGURA-1:0] pc, pc_mais4, end_desc;
    logic [LARGURA-1:0] buf_instr, buf_pc4;
    logic               buf_cheio;
    logic               req, ack;

    assign pc_mais4    = pc + LARGURA'(4);
    assign req         = (estado == BUSCA) || (estado == DESCARTE);
    assign ack         = req & mem.mem_ack;
    assign mem.mem_req = req;
    // A flushed request keeps presenting its original address until memory acks it.
    assign mem.mem_end = (estado == DESCARTE) ? end_desc : pc;

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:   prox = BUSCA;
            BUSCA: begin
                if (PCSrc)    prox = ack ? BUSCA : DESCARTE;
                else if (ack) prox = stall ? SEGURA : BUSCA;
            end
            SEGURA:   if (PCSrc || !stall) prox = BUSCA;
            DESCARTE: if (ack) prox = BUSCA;
            default:  prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado    <= OCIOSO;
            pc        <= PC_RESET;
            end_desc  <= '0;
            instrucao <= '0;
            PC4       <= '0;
            if_valido <= 1'b0;
            buf_instr <= '0;
            buf_pc4   <= '0;
            buf_cheio <= 1'b0;
        end else begin
            estado <= prox;
            if (PCSrc) begin
                pc        <= branch;
                if_valido <= 1'b0;
                buf_cheio <= 1'b0;
                if (estado == BUSCA) end_desc <= pc;
            end else begin
                case (estado)
                    BUSCA: begin
                        if (ack) begin
                            pc <= pc_mais4;
                            // ID still holds an unconsumed word: park the new one.
                            if (stall && if_valido) begin
                                buf_instr <= mem.mem_dado;
                                buf_pc4   <= pc_mais4;
                                buf_cheio <= 1'b1;
                            end else begin
                                instrucao <= mem.mem_dado;
                                PC4       <= pc_mais4;
                                if_valido <= 1'b1;
                            end
                        end else if (!stall) begin
                            if_valido <= 1'b0;
                        end
                    end
                    SEGURA: begin
                        if (!stall) begin
                            if (buf_cheio) begin
                                instrucao <= buf_instr;
                                PC4       <= buf_pc4;
                                if_valido <= 1'b1;
                                buf_cheio <= 1'b0;
                            end else begin
                                if_valido <= 1'b0;
                            end
                        end
                    end
                    default: if (!stall) if_valido <= 1'b0;
                endcase
            end
        end
    end

`ifdef IF_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
    logic [CW-1:0] cnt;
    logic          erro;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt  <= '0;
            erro <= 1'b0;
        end else if (ack) begin
            cnt <= '0;
        end else if (req) begin
            if (cnt != CW'(TIMEOUT_CICLOS)) cnt <= cnt + CW'(1);
            if (cnt == CW'(TIMEOUT_CICLOS - 1)) erro <= 1'b1;
        end
    end
    assign timeout_erro = erro;
`else
    assign timeout_erro = 1'b0;
`endif
endmodule
